// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard and sequencing controller for the 5-stage core.
//   Drives the stall enables and synchronous clears of the IF/ID, ID/EX and
//   EX/MEM registers and produces the EX-stage forwarding selects.
//   Sequences a post-reset flush, load-use stalls / branch flushes, and
//   multi-cycle EX operations that occupy EX for MC_LAT cycles.
//
// Handshake: there is no valid/ready traffic here. Every stall/flush output is
//   a level that the pipeline registers sample at the same rising edge of
//   `clock`; a stall holds the register, a flush clears it, and the two are
//   never asserted together on the same register.
//
// Ports
//   clock, reset                 clock (rising edge), async active-high reset
//   rs1_d, rs2_d                 sources of the instruction in ID
//   rs1_e, rs2_e, rd_e           sources/destination of the instruction in EX
//   mem_to_reg_e                 instruction in EX is a load
//   reg_write_m, rd_m            MEM-stage writeback enable / destination
//   reg_write_w, rd_w            WB-stage writeback enable / destination
//   branch_taken_e               PC redirect resolved in EX
//   mc_start_e                   instruction in EX is multi-cycle
//   stall_f, stall_d, stall_e    hold PC, IF/ID, ID/EX
//   flush_d, flush_e, flush_m    clear IF/ID, ID/EX, EX/MEM
//   fwd_a_e, fwd_b_e             00 regfile, 10 MEM result, 01 WB result
//   mc_busy                      multi-cycle wait in progress
//   dbg_state                    current FSM state (0 STARTUP, 1 RUN, 2 MC_WAIT)
module hazard_ctrl #(
  parameter int REG_W          = 5,
  parameter int MC_LAT         = 4,
  parameter int STARTUP_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rs1_e,
  input  logic [REG_W-1:0] rs2_e,
  input  logic [REG_W-1:0] rd_e,
  input  logic             mem_to_reg_e,
  input  logic             reg_write_m,
  input  logic [REG_W-1:0] rd_m,
  input  logic             reg_write_w,
  input  logic [REG_W-1:0] rd_w,
  input  logic             branch_taken_e,
  input  logic             mc_start_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             mc_busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1,
    ST_MC_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] CNT_STARTUP = 8'(STARTUP_CYCLES - 1);
  localparam logic [7:0] CNT_MC      = 8'(MC_LAT - 2);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       lw;

  // Load-use: the load in EX writes a register the instruction in ID reads.
  // x0 is never a real dependency.
  assign lw = mem_to_reg_e && (rd_e != '0) &&
              ((rd_e == rs1_d) || (rd_e == rs2_d));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_STARTUP;
      cnt_q   <= CNT_STARTUP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    mc_busy = 1'b0;

    unique case (state_q)
      ST_STARTUP: begin
        flush_d = 1'b1;
        flush_e = 1'b1;
        flush_m = 1'b1;
        if (cnt_q == 8'd0) state_d = ST_RUN;
        else               cnt_d   = cnt_q - 8'd1;
      end

      ST_RUN: begin
        if (mc_start_e) begin
          // The op's first EX cycle: hold everything upstream and keep a
          // bubble flowing into MEM until the result is ready.
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
          cnt_d   = CNT_MC;
          state_d = ST_MC_WAIT;
        end else begin
          flush_d = branch_taken_e;
          flush_e = lw || branch_taken_e;
          // A taken branch discards the dependent instruction anyway, so it
          // overrides the stall and the redirect proceeds.
          stall_f = lw && !branch_taken_e;
          stall_d = lw && !branch_taken_e;
        end
      end

      ST_MC_WAIT: begin
        mc_busy = 1'b1;
        if (cnt_q != 8'd0) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
          cnt_d   = cnt_q - 8'd1;
        end else begin
          // Last EX cycle: the op advances to MEM at the end of this cycle.
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_STARTUP;
        cnt_d   = CNT_STARTUP;
      end
    endcase
  end

  // Forwarding is independent of the FSM; MEM has priority (newer result).
  always_comb begin
    fwd_a_e = 2'b00;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))      fwd_a_e = 2'b10;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e)) fwd_a_e = 2'b01;
  end

  always_comb begin
    fwd_b_e = 2'b00;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))      fwd_b_e = 2'b10;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e)) fwd_b_e = 2'b01;
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl (REG_W=5, MC_LAT=4, STARTUP_CYCLES=2).
// Inputs are driven on the falling edge; the expected output vector for that
// cycle is pushed to exp_q and popped/compared 2 ns later, well before the
// next rising edge. Output vector layout:
//   {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy, fwd_a_e, fwd_b_e}
module tb_hazard_ctrl;

  localparam int REG_W = 5;

  // Expected-vector constants for the control part (forwarding bits 00).
  localparam logic [10:0] E_CLR   = 11'b000_000_0_00_00;
  localparam logic [10:0] E_FLUSH = 11'b000_111_0_00_00;
  localparam logic [10:0] E_LU    = 11'b110_010_0_00_00;
  localparam logic [10:0] E_BR    = 11'b000_110_0_00_00;
  localparam logic [10:0] E_MC    = 11'b111_001_0_00_00;
  localparam logic [10:0] E_MCW   = 11'b111_001_1_00_00;
  localparam logic [10:0] E_MCEND = 11'b000_000_1_00_00;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [REG_W-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic mem_to_reg_e, reg_write_m, reg_write_w, branch_taken_e, mc_start_e;
  logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy;
  logic [1:0] fwd_a_e, fwd_b_e, dbg_state;

  hazard_ctrl #(.REG_W(REG_W), .MC_LAT(4), .STARTUP_CYCLES(2)) dut (
    .clock(clock), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .mem_to_reg_e(mem_to_reg_e),
    .reg_write_m(reg_write_m), .rd_m(rd_m),
    .reg_write_w(reg_write_w), .rd_w(rd_w),
    .branch_taken_e(branch_taken_e), .mc_start_e(mc_start_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .mc_busy(mc_busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [10:0] got,
                          input logic [10:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0;
    rd_m = '0; rd_w = '0;
    mem_to_reg_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
    branch_taken_e = 1'b0; mc_start_e = 1'b0;
  endtask

  // Called right after a falling edge with inputs already set: records the
  // expectation, checks it mid-low-phase, then waits for the next falling edge.
  task automatic cycle(input string tag, input logic [10:0] exp);
    logic [10:0] got;
    exp_q.push_back(exp);
    #2;
    got = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy,
           fwd_a_e, fwd_b_e};
    check_eq(tag, got, exp_q.pop_front());
    @(negedge clock);
  endtask

  function automatic logic [1:0] fwd_ref(input logic wm, input logic [REG_W-1:0] dm,
                                         input logic ww, input logic [REG_W-1:0] dw,
                                         input logic [REG_W-1:0] rs);
    if (wm && dm != 0 && dm == rs) return 2'b10;
    if (ww && dw != 0 && dw == rs) return 2'b01;
    return 2'b00;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    @(negedge clock);

    // Held in reset: all flushes, no stalls.
    cycle("rst_hold0", E_FLUSH);
    cycle("rst_hold1", E_FLUSH);

    // Release: exactly two STARTUP cycles; hazard inputs are ignored there.
    reset = 1'b0;
    mem_to_reg_e = 1'b1; rd_e = 5'd5; rs2_d = 5'd5; mc_start_e = 1'b1;
    cycle("startup0", E_FLUSH);
    cycle("startup1", E_FLUSH);
    clear_inputs();
    cycle("run_idle", E_CLR);

    // Load-use via rs2: one bubble.
    mem_to_reg_e = 1'b1; rd_e = 5'd5; rs2_d = 5'd5;
    cycle("lu_rs2", E_LU);
    clear_inputs();
    cycle("lu_after", E_CLR);
    // Load into x0 is not a hazard.
    mem_to_reg_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
    cycle("lu_x0", E_CLR);
    // Non-load with matching register is not a hazard.
    mem_to_reg_e = 1'b0; rd_e = 5'd3; rs1_d = 5'd3;
    cycle("nonload", E_CLR);

    // Load-use together with a taken branch: branch wins.
    mem_to_reg_e = 1'b1; rd_e = 5'd3; rs1_d = 5'd3; branch_taken_e = 1'b1;
    cycle("lu_branch", E_BR);
    clear_inputs();
    branch_taken_e = 1'b1;
    cycle("branch", E_BR);
    clear_inputs();

    // Multi-cycle op (MC_LAT=4); branch/load-use in the start cycle ignored.
    mc_start_e = 1'b1; branch_taken_e = 1'b1;
    mem_to_reg_e = 1'b1; rd_e = 5'd4; rs1_d = 5'd4;
    cycle("mc_start", E_MC);
    clear_inputs();
    mc_start_e = 1'b1;
    cycle("mc_wait1", E_MCW);
    mc_start_e = 1'b0; branch_taken_e = 1'b1;
    cycle("mc_wait2_br", E_MCW);
    branch_taken_e = 1'b0;
    cycle("mc_wait3_end", E_MCEND);
    cycle("mc_run", E_CLR);

    // Directed forwarding.
    rd_m = 5'd7; rd_w = 5'd7; reg_write_m = 1'b1; reg_write_w = 1'b1; rs1_e = 5'd7;
    cycle("fwd_a_mem", 11'b000_000_0_10_00);
    reg_write_m = 1'b0;
    cycle("fwd_a_wb", 11'b000_000_0_01_00);
    rd_m = 5'd0; rd_w = 5'd0; reg_write_m = 1'b1; rs1_e = 5'd0;
    cycle("fwd_a_x0", 11'b000_000_0_00_00);
    rd_m = 5'd9; rd_w = 5'd7; rs1_e = 5'd7; rs2_e = 5'd9;
    cycle("fwd_ab_mix", 11'b000_000_0_01_10);
    clear_inputs();

    // Random forwarding in RUN with no control hazards.
    for (int i = 0; i < 24; i++) begin
      reg_write_m = 1'($urandom_range(0, 1));
      reg_write_w = 1'($urandom_range(0, 1));
      rd_m  = 5'($urandom_range(0, 3));
      rd_w  = 5'($urandom_range(0, 3));
      rs1_e = 5'($urandom_range(0, 3));
      rs2_e = 5'($urandom_range(0, 3));
      cycle("fwd_rand", {7'b0,
                         fwd_ref(reg_write_m, rd_m, reg_write_w, rd_w, rs1_e),
                         fwd_ref(reg_write_m, rd_m, reg_write_w, rd_w, rs2_e)});
    end
    clear_inputs();

    // Reset in the second MC_WAIT cycle abandons the wait at once.
    mc_start_e = 1'b1;
    cycle("mc2_start", E_MC);
    mc_start_e = 1'b0;
    cycle("mc2_wait1", E_MCW);
    reset = 1'b1;
    cycle("mc2_reset", E_FLUSH);
    reset = 1'b0;
    cycle("restart0", E_FLUSH);
    cycle("restart1", E_FLUSH);
    cycle("restart_run", E_CLR);

    // Short multi-cycle wait after restart to confirm normal sequencing.
    mc_start_e = 1'b1;
    cycle("mc3_start", E_MC);
    mc_start_e = 1'b0;
    cycle("mc3_wait1", E_MCW);
    cycle("mc3_wait2", E_MCW);
    cycle("mc3_wait3", E_MCEND);
    cycle("mc3_run", E_CLR);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage processor. It drives the stall enables and synchronous-clear (`clr`) inputs of the IF/ID, ID/EX and EX/MEM pipeline registers, and produces the EX-stage forwarding selects. It sequences three things: a post-reset pipeline flush, load-use stalls with branch flushes, and multi-cycle EX operations (mul/div) that hold the EX stage for `MC_LAT` cycles.

## Interface
- `REG_W`, 5, register-index width
- `MC_LAT`, 4, EX occupancy in cycles of a multi-cycle op (legal range ≥2)
- `STARTUP_CYCLES`, 2, cycles of forced flush after reset release (legal range ≥1, ≤255)
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `rs1_d`, `rs2_d`  in  REG_W  source registers of the instruction in ID
- `rs1_e`, `rs2_e`, `rd_e`  in  REG_W  sources and destination of the instruction in EX
- `mem_to_reg_e`  in  1  instruction in EX is a load
- `reg_write_m`, `rd_m`  in  1, REG_W  MEM-stage writeback enable and destination
- `reg_write_w`, `rd_w`  in  1, REG_W  WB-stage writeback enable and destination
- `branch_taken_e`  in  1  PC redirect resolved in EX
- `mc_start_e`  in  1  instruction in EX is multi-cycle
- `stall_f`, `stall_d`, `stall_e`  out  1  hold PC, IF/ID and ID/EX respectively
- `flush_d`, `flush_e`, `flush_m`  out  1  `clr` for IF/ID, ID/EX and EX/MEM
- `fwd_a_e`, `fwd_b_e`  out  2  operand select: 00 register file, 10 MEM result, 01 WB result
- `mc_busy`  out  1  multi-cycle wait in progress

## Operation
- FSM states: STARTUP, RUN, MC_WAIT. There is one down-counter `cnt` of 8 bits.
- Reset, asynchronous: state is STARTUP and `cnt` is `STARTUP_CYCLES`-1.
  - Outputs during reset: `flush_d`=`flush_e`=`flush_m`=1; all stalls 0; `mc_busy`=0.
  - `fwd_*` stay combinational during reset.
- STARTUP:
  - Assert all three flushes; no stalls.
  - If `cnt`==0, go to RUN; otherwise decrement `cnt`.
  - Ignore all hazard inputs.
- RUN: compute `lw` = `mem_to_reg_e` & (`rd_e`≠0) & (`rd_e`==`rs1_d` | `rd_e`==`rs2_d`).
  - If `mc_start_e`:
    - Assert `stall_f`, `stall_d`, `stall_e` and `flush_m`.
    - Set `cnt` to `MC_LAT`-2 and go to MC_WAIT.
    - `lw` and `branch_taken_e` are ignored this cycle.
  - Otherwise:
    - `flush_d` = `branch_taken_e`.
    - `flush_e` = `lw` | `branch_taken_e`.
    - `stall_f` = `stall_d` = `lw` & ~`branch_taken_e`. A branch overrides the load-use stall so the redirect is not blocked.
    - `stall_e` = 0 and `flush_m` = 0.
- MC_WAIT: `mc_busy`=1; ignore `mc_start_e`, `lw` and `branch_taken_e`.
  - If `cnt`≠0: assert `stall_f`, `stall_d`, `stall_e` and `flush_m`, then decrement `cnt`.
  - If `cnt`==0: all stalls and flushes are 0, and the state returns to RUN. The op leaves EX at the end of this cycle.
- Invariants:
  - `flush_e` is never 1 while `stall_e` is 1.
  - `flush_d` is never 1 while `stall_d` is 1.
- Forwarding is purely combinational and independent of state. For `fwd_a_e`:
  - 10 if `reg_write_m` & `rd_m`≠0 & `rd_m`==`rs1_e`.
  - Else 01 if `reg_write_w` & `rd_w`≠0 & `rd_w`==`rs1_e`.
  - Else 00.
  - MEM takes priority over WB. `fwd_b_e` is identical, using `rs2_e`.

## Timing
- Stall and flush outputs are combinational from the registered state, `cnt` and the current inputs. They are sampled by the pipeline registers at the same rising edge.
- STARTUP lasts exactly `STARTUP_CYCLES` cycles after `reset` falls.
- Load-use costs 1 bubble. A taken branch costs 2 flushed slots.
- Multi-cycle op first seen in EX at cycle t:
  - Stalls are asserted in cycles t .. t+`MC_LAT`-2, which is `MC_LAT`-1 cycles.
  - Stalls are 0 in cycle t+`MC_LAT`-1.
  - EX is occupied for exactly `MC_LAT` cycles.
  - `flush_m` is asserted in the same cycles as the stalls.
- When `MC_LAT`=2, MC_WAIT lasts one cycle with `cnt`=0 and asserts no stalls.
- Reset asserted in any state, including mid MC_WAIT, returns the block to STARTUP immediately and abandons the remaining count.

## Test plan
- Reset with `STARTUP_CYCLES`=2, then release → `flush_d`/`flush_e`/`flush_m` stay 1 for exactly 2 cycles, then 0; stalls stay 0 throughout.
- In RUN, `mem_to_reg_e`=1, `rd_e`=5, `rs2_d`=5 → `stall_f`=`stall_d`=`flush_e`=1 for 1 cycle. Repeat with `rd_e`=0 → no stall.
- Load-use (`rd_e`=3, `rs1_d`=3) together with `branch_taken_e`=1 → `flush_d`=`flush_e`=1 and `stall_f`=`stall_d`=0.
- `mc_start_e`=1 with `MC_LAT`=4 → stalls and `flush_m` high for 3 cycles; `mc_busy` high for the 3 MC_WAIT cycles; the 4th cycle is clear; `branch_taken_e` pulsed mid-wait has no effect.
- `rd_m`=`rd_w`=7, both with writeback enabled, `rs1_e`=7 → `fwd_a_e`=10. Drop `reg_write_m` → 01. Set `rd_m`=`rd_w`=0 → 00.
- Assert `reset` in the second MC_WAIT cycle → the same cycle shows `mc_busy`=0, all flushes 1 and stalls 0; the normal STARTUP sequence follows release.
